// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_rx_if.sv
// Consumer-side handshake of the UART receiver: received byte, status flags and ack.
interface uart_rx_if;
    import uart_pkg::*;

    logic                 rx_ack;
    logic [DATA_BITS-1:0] dout;
    logic                 rx_valid;
    logic                 overrun;
    logic                 frame_err;
    logic                 busy;

    modport master (
        input  rx_ack,
        output dout,
        output rx_valid,
        output overrun,
        output frame_err,
        output busy
    );

    modport slave (
        output rx_ack,
        input  dout,
        input  rx_valid,
        input  overrun,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; RESET_VAL sets the
// value both flops take during reset (idle level of the line).
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta_reg;
    logic q_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_reg <= RESET_VAL;
            q_reg    <= RESET_VAL;
        end else begin
            meta_reg <= d;
            q_reg    <= meta_reg;
        end
    end

    assign q = q_reg;
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a cycle counter, one-entry holding
// register with valid/ack handshake, sticky overrun and a frame-error pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic      fpga_clk,
    input  logic      rst,
    input  logic      sin,
    uart_rx_if.master rx
);
    localparam int            HALF     = CLKS_PER_BIT / 2;
    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

    logic                 sin_s;
    rx_state_t            state_reg, state_next;
    logic [CW-1:0]        cnt_reg, cnt_next;
    logic [2:0]           bit_idx_reg, bit_idx_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [DATA_BITS-1:0] dout_reg, dout_next;
    logic                 rx_valid_reg, rx_valid_next;
    logic                 overrun_reg, overrun_next;
    logic                 frame_err_reg, frame_err_next;
    logic                 deliver;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk (fpga_clk),
        .rst (rst),
        .d   (sin),
        .q   (sin_s)
    );

    always_ff @(posedge fpga_clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            bit_idx_reg   <= '0;
            shift_reg     <= '0;
            dout_reg      <= '0;
            rx_valid_reg  <= 1'b0;
            overrun_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            bit_idx_reg   <= bit_idx_next;
            shift_reg     <= shift_next;
            dout_reg      <= dout_next;
            rx_valid_reg  <= rx_valid_next;
            overrun_reg   <= overrun_next;
            frame_err_reg <= frame_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        bit_idx_next   = bit_idx_reg;
        shift_next     = shift_reg;
        dout_next      = dout_reg;
        rx_valid_next  = rx_valid_reg;
        overrun_next   = overrun_reg;
        frame_err_next = 1'b0;
        deliver        = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (!sin_s) begin
                    state_next = START;
                    cnt_next   = '0;
                end
            end
            START: begin
                // A start bit that is high again at its midpoint was only a glitch.
                if (cnt_reg == CNT_HALF) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    state_next   = sin_s ? IDLE : DATA;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DATA: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next   = '0;
                    shift_next = {sin_s, shift_reg[DATA_BITS-1:1]};
                    if (bit_idx_reg == BIT_LAST) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            STOP: begin
                // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
                if (cnt_reg == CNT_LAST) begin
                    cnt_next       = '0;
                    state_next     = IDLE;
                    deliver        = sin_s;
                    frame_err_next = !sin_s;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (deliver) begin
            dout_next     = shift_reg;
            rx_valid_next = 1'b1;
            if (rx.rx_ack) begin
                overrun_next = 1'b0;
            end else if (rx_valid_reg) begin
                overrun_next = 1'b1;
            end
        end else if (rx.rx_ack && rx_valid_reg) begin
            rx_valid_next = 1'b0;
            overrun_next  = 1'b0;
        end
    end

    assign rx.dout      = dout_reg;
    assign rx.rx_valid  = rx_valid_reg;
    assign rx.overrun   = overrun_reg;
    assign rx.frame_err = frame_err_reg;
    assign rx.busy      = (state_reg != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx with a behavioural serial line driver.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
    localparam int LAT  = 2 + HALF + 9 * CPB + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        bit         ovr;
        bit         valid;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic sin;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t sb[$];

    bit         m_valid = 1'b0;
    bit         m_ovr   = 1'b0;
    logic [7:0] m_dout  = 8'h00;

    uart_rx_if rx_if ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .fpga_clk (clk),
        .rst      (rst),
        .sin      (sin),
        .rx       (rx_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a falling edge; drives one 10-bit frame and returns at a falling edge.
    // ack_c: frame cycle at which rx_ack pulses (-1 none, LAT-1 = same cycle as delivery).
    // abort_c: frame cycle at which reset is asserted (-1 none).
    task automatic send_frame(input logic [7:0] b, input bit stop, input int ack_c, input int abort_c);
        logic [9:0] bits;
        exp_t       e;
        bits = {stop, b, 1'b0};
        if (abort_c < 0) begin
            if (ack_c >= 0 && ack_c < LAT - 1) begin
                m_valid = 1'b0;
                m_ovr   = 1'b0;
            end
            if (stop) begin
                if (ack_c == LAT - 1) m_ovr = 1'b0;
                else if (m_valid)     m_ovr = 1'b1;
                m_valid = 1'b1;
                m_dout  = b;
            end
            e.is_err = !stop;
            e.data   = m_dout;
            e.ovr    = m_ovr;
            e.valid  = m_valid;
            e.cyc    = cyc + LAT;
            sb.push_back(e);
        end
        for (int c = 0; c < 10 * CPB; c++) begin
            if (c == abort_c) begin
                rst = 1'b1;
                #1;
                check("reset_dout", rx_if.dout, 8'h00);
                check("reset_valid", rx_if.rx_valid, 1'b0);
                check("reset_overrun", rx_if.overrun, 1'b0);
                check("reset_frame_err", rx_if.frame_err, 1'b0);
                check("reset_busy", rx_if.busy, 1'b0);
                m_valid = 1'b0;
                m_ovr   = 1'b0;
                m_dout  = 8'h00;
                sin = 1'b1;
                rx_if.rx_ack = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            sin = bits[c / CPB];
            rx_if.rx_ack = (c == ack_c);
            @(negedge clk);
        end
        sin = 1'b1;
        rx_if.rx_ack = 1'b0;
    endtask

    task automatic do_ack();
        rx_if.rx_ack = 1'b1;
        @(posedge clk);
        #1;
        check("ack_valid", rx_if.rx_valid, 1'b0);
        check("ack_overrun", rx_if.overrun, 1'b0);
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        @(negedge clk);
        rx_if.rx_ack = 1'b0;
    endtask

    // Monitor: a delivery shows as rx_valid rising, or staying high across an ack,
    // a new dout, or overrun rising; each delivery or frame_err pops one expectation.
    bit         p_valid = 1'b0;
    bit         p_ovr   = 1'b0;
    logic [7:0] p_dout  = 8'h00;

    initial begin
        bit   ev;
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                ev = rx_if.rx_valid && (!p_valid || rx_if.rx_ack ||
                     rx_if.dout != p_dout || (rx_if.overrun && !p_ovr));
                if (ev || rx_if.frame_err) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: actual valid=%0b frame_err=%0b dout=%0h required no event (cycle %0d)",
                                 rx_if.rx_valid, rx_if.frame_err, rx_if.dout, cyc);
                    end else begin
                        e = sb.pop_front();
                        check("event_kind_frame_err", rx_if.frame_err, e.is_err);
                        check("dout", rx_if.dout, e.data);
                        check("rx_valid", rx_if.rx_valid, e.valid);
                        check("overrun", rx_if.overrun, e.ovr);
                        checks++;
                        if (cyc < e.cyc - 1 || cyc > e.cyc + 1) begin
                            errors++;
                            $display("FAIL latency: actual cycle %0d required %0d +/-1", cyc, e.cyc);
                        end
                    end
                end
            end
            p_valid = rx_if.rx_valid;
            p_ovr   = rx_if.overrun;
            p_dout  = rx_if.dout;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: actual cycle %0d required finish", cyc);
        errors++;
        $fatal(1, "bench timeout");
    end

    initial begin
        int mode;
        int gap;
        bit stop;
        logic [7:0] b;

        rst = 1'b1;
        sin = 1'b1;
        rx_if.rx_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dout", rx_if.dout, 8'h00);
        check("rst_valid", rx_if.rx_valid, 1'b0);
        check("rst_overrun", rx_if.overrun, 1'b0);
        check("rst_frame_err", rx_if.frame_err, 1'b0);
        check("rst_busy", rx_if.busy, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single byte, then ack.
        send_frame(8'hAA, 1'b1, -1, -1);
        check("aa_valid", rx_if.rx_valid, 1'b1);
        check("aa_dout", rx_if.dout, 8'hAA);
        do_ack();

        // Back-to-back; first byte acked during the second frame.
        send_frame(8'h46, 1'b1, -1, -1);
        send_frame(8'h00, 1'b1, 20, -1);
        do_ack();

        // Short low glitch.
        sin = 1'b0;
        repeat (4) @(negedge clk);
        sin = 1'b1;
        @(posedge clk);
        #1;
        check("glitch_busy_high", rx_if.busy, 1'b1);
        repeat (12) @(negedge clk);
        check("glitch_busy_low", rx_if.busy, 1'b0);
        check("glitch_no_valid", rx_if.rx_valid, 1'b0);

        // Stop bit low.
        send_frame(8'h3C, 1'b0, -1, -1);
        repeat (4) @(negedge clk);
        check("ferr_valid", rx_if.rx_valid, 1'b0);
        check("ferr_dout_kept", rx_if.dout, 8'h00);

        // Overrun, then ack coincident with the third delivery.
        send_frame(8'h11, 1'b1, -1, -1);
        send_frame(8'h22, 1'b1, -1, -1);
        check("ovr_dout", rx_if.dout, 8'h22);
        check("ovr_flag", rx_if.overrun, 1'b1);
        send_frame(8'h33, 1'b1, LAT - 1, -1);
        check("coinc_dout", rx_if.dout, 8'h33);
        check("coinc_valid", rx_if.rx_valid, 1'b1);
        check("coinc_overrun", rx_if.overrun, 1'b0);

        // Reset during data bit 4, then a clean frame.
        send_frame(8'h77, 1'b1, -1, CPB * 5 + HALF);
        repeat (3) @(negedge clk);
        send_frame(8'h5A, 1'b1, -1, -1);
        check("post_reset_dout", rx_if.dout, 8'h5A);
        do_ack();

        // Randomized frames, ack policies and idle gaps.
        for (int i = 0; i < 24; i++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            mode = $urandom_range(0, 2);
            if (mode == 2 && m_valid) mode = 0;
            if (!stop) begin
                send_frame(b, 1'b0, -1, -1);
            end else if (mode == 1) begin
                send_frame(b, 1'b1, LAT - 1, -1);
            end else begin
                send_frame(b, 1'b1, -1, -1);
            end
            if (mode == 0 || (mode == 1 && $urandom_range(0, 1) == 1)) do_ack();
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
        end

        repeat (20) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Byte-wide UART receiver, the receive-side counterpart of `uart_tx`. Recovers 8N1 frames (one start bit, 8 data bits LSB first, one stop bit, idle high) from the serial line. Uses a 2-flop synchronizer, a counter-based mid-bit sampler and a one-entry holding register with valid/ack handshake. Sits between the FPGA RX pin and the byte consumer.

## Interface
- `CLKS_PER_BIT`, default 868: `fpga_clk` cycles per bit (100 MHz / 115200). Must be even and ≥ 8.
- `fpga_clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `sin`  in  1  asynchronous serial input, idle high.
- `rx_ack`  in  1  consumer has taken `dout`; clears `rx_valid` and `overrun`.
- `dout`  out  8  last received byte, held until overwritten.
- `rx_valid`  out  1  `dout` holds an unacknowledged byte (level).
- `overrun`  out  1  sticky: a byte completed while `rx_valid` was already 1.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low; byte discarded.
- `busy`  out  1  FSM not in IDLE.

## Operation
- Reset values: `dout`=8'h00, `rx_valid`=0, `overrun`=0, `frame_err`=0, `busy`=0. Synchronizer flops reset to 1, FSM to IDLE, bit counter and shift register to 0.
- `sin` passes through two flops to give `sin_s`. Only `sin_s` is used internally.
- HALF = CLKS_PER_BIT/2.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - `sin_s`==0 → START, cycle counter cleared.
- START:
  - Counter counts up. At cnt==HALF-1, sample `sin_s`.
  - Sample 1 (glitch) → IDLE.
  - Sample 0 → DATA, counter cleared, bit index = 0.
- DATA:
  - At cnt==CLKS_PER_BIT-1, sample `sin_s`, shift it into the shift register MSB-first, so the first bit lands in bit 0 after 8 shifts.
  - Bit index increments; counter clears.
  - After bit index 7 → STOP.
- STOP:
  - At cnt==CLKS_PER_BIT-1, sample `sin_s`, then → IDLE. Returning at mid-stop allows back-to-back frames.
  - Sample 1 → byte delivered: `dout` loaded, `rx_valid` set.
  - Sample 0 → `frame_err` pulses; `dout`, `rx_valid` and `overrun` unchanged.
- Holding register rules:
  - Delivery with `rx_valid`==0 → `rx_valid`=1.
  - Delivery with `rx_valid`==1 and no `rx_ack` → `dout` overwritten with the new byte; `overrun`=1.
  - `rx_ack` with no delivery → `rx_valid`=0, `overrun`=0.
  - `rx_ack` and delivery in the same cycle → new byte loaded, `rx_valid` stays 1, `overrun`=0.
  - `rx_ack` while `rx_valid`==0 → no effect.
- `busy` = (state != IDLE).
- Reset asserted mid-frame → all state returns to reset values immediately; no partial byte is delivered. A line that is low when reset releases is treated as a start edge.

## Timing
- Synchronizer latency: 2 cycles.
- Start sample: HALF cycles after `sin_s` falls. Each data/stop sample is CLKS_PER_BIT cycles after the previous sample.
- `rx_valid`/`dout`/`frame_err` are registered and update on the cycle after the stop sample.
- Latency from `sin` falling edge to `rx_valid` rise: 2 + HALF + 9·CLKS_PER_BIT + 1 cycles (±1 for input phase).
- Tolerates up to ±(HALF−1)/(10·CLKS_PER_BIT) baud mismatch; no resynchronization within a frame.
- Counter width: $clog2(CLKS_PER_BIT). Bit index: 3 bits, no wrap beyond 7.

## Structure
- `uart_pkg`:
  - `rx_state_t` enum {IDLE, START, DATA, STOP}.
  - Frame constants: DATA_BITS=8, default CLKS_PER_BIT.
  - Shared with `uart_tx`.
- One sub-module, `uart_sync2`: 2-flop synchronizer with a reset-value parameter; reused for other async inputs.
- FSM, counters, shift register and holding register live in `uart_rx`.

## Test plan
Bench uses CLKS_PER_BIT=16 with a behavioural line driver.
- Send 0xAA (line: 0,0,1,0,1,0,1,0,1,1) → `rx_valid`=1 at the computed latency, `dout`=8'hAA, `frame_err` never pulses; `rx_ack` → `rx_valid`=0.
- Send 0x46 then 0x00 back-to-back, acking each → `dout` sequence 0x46, 0x00; `overrun`=0.
- Pull `sin` low for 4 cycles, then high → `busy` drops after the start sample; no `rx_valid`, no `frame_err`.
- Frame 0x3C with stop bit 0 → one-cycle `frame_err` pulse; `rx_valid` stays 0, `dout` keeps its prior value.
- Send 0x11 then 0x22 with no ack → `dout`=8'h22, `rx_valid`=1, `overrun`=1. Ack on the same cycle as a third byte 0x33 completes → `dout`=0x33, `rx_valid`=1, `overrun`=0.
- Assert `rst` during data bit 4 → all outputs 0 at once; after release, send 0x5A → `dout`=8'h5A.
